// File: rtl/i2c_target.sv
// I2C target responder: decodes START/STOP, matches a 7-bit address, ACKs, and
// maps bus writes/reads onto a byte-wide register interface with an auto-incrementing pointer.
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_MACK, IGNORE
  } state_t;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic [7:0] tx, tx_n;
  logic [7:0] ptr, ptr_n;
  logic       rw, rw_n;
  logic       ack_drv, ack_drv_n;
  logic       mack, mack_n;
  logic       rd_pend;
  logic       sda_oe_n, busy_n, wr_en_n, rd_req_n;
  logic [7:0] wr_addr_n, wr_data_n, rd_addr_n;

  // Two synchroniser flops plus one history flop per line; idle bus reads as high.
  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the previous value, forming a real shift chain.
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_byte   = {shreg[6:0], sda_s2};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tx      <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      ack_drv <= 1'b0;
      mack    <= 1'b0;
      rd_pend <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_req  <= 1'b0;
      rd_addr <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
      ptr     <= ptr_n;
      rw      <= rw_n;
      ack_drv <= ack_drv_n;
      mack    <= mack_n;
      rd_pend <= rd_req;
      sda_oe  <= sda_oe_n;
      busy    <= busy_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      rd_req  <= rd_req_n;
      rd_addr <= rd_addr_n;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    tx_n      = tx;
    ptr_n     = ptr;
    rw_n      = rw;
    ack_drv_n = ack_drv;
    mack_n    = mack;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    rd_req_n  = 1'b0;
    rd_addr_n = rd_addr;

    // Read data arrives one clk after the rd_req pulse.
    if (rd_pend) tx_n = rd_data;

    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      ack_drv_n = 1'b0;
      mack_n    = 1'b0;
    end else if (stop_det) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      ack_drv_n = 1'b0;
      mack_n    = 1'b0;
    end else begin
      case (state)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_byte[7:1] == ADDRESS) begin
              busy_n    = 1'b1;
              rw_n      = rx_byte[0];
              ack_drv_n = 1'b0;
              state_n   = ADDR_ACK;
              if (rx_byte[0]) begin
                rd_req_n  = 1'b1;
                rd_addr_n = ptr;
              end
            end else begin
              state_n = IGNORE;
            end
          end
        end
        // First fall after the byte pulls SDA low; the following fall releases it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!ack_drv) begin
            sda_oe_n  = 1'b1;
            ack_drv_n = 1'b1;
          end else begin
            ack_drv_n = 1'b0;
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (state == ADDR_ACK) begin
              if (rw) begin
                state_n  = RDATA;
                sda_oe_n = ~tx[7];
              end else begin
                state_n = PTR;
              end
            end else begin
              state_n = WDATA;
            end
          end
        end
        PTR: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            ptr_n   = rx_byte;
            state_n = PTR_ACK;
          end
        end
        WDATA: if (scl_rise) begin
          shreg_n   = rx_byte;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            wr_en_n   = 1'b1;
            wr_addr_n = ptr;
            wr_data_n = rx_byte;
            ptr_n     = ptr + 8'd1;
            state_n   = WDATA_ACK;
          end
        end
        RDATA: if (scl_fall) begin
          if (bit_cnt == 3'd7) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            mack_n    = 1'b0;
            state_n   = RD_MACK;
          end else begin
            tx_n      = {tx[6:0], 1'b0};
            sda_oe_n  = ~tx[6];
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
        RD_MACK: begin
          if (scl_rise && !mack) begin
            ptr_n = ptr + 8'd1;
            if (!sda_s2) begin
              mack_n    = 1'b1;
              rd_req_n  = 1'b1;
              rd_addr_n = ptr + 8'd1;
            end else begin
              state_n  = IGNORE;
              busy_n   = 1'b0;
              sda_oe_n = 1'b0;
            end
          end else if (scl_fall && mack) begin
            mack_n    = 1'b0;
            bit_cnt_n = '0;
            sda_oe_n  = ~tx[7];
            state_n   = RDATA;
          end
        end
        IGNORE: begin
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

endmodule
